// File: rtl/hp_pkg.sv
// Shared definitions for the hogge phase-detector sensor chain: controller
// state encodings, default parameter values and a counter-width helper.
package hp_pkg;

  // Qualification controller states
  typedef enum logic [1:0] {
    ARMING  = 2'd0,
    MONITOR = 2'd1,
    FAULT   = 2'd2
  } hp_state_e;

  // Default tuning of the alarm qualification stage
  localparam int HP_SYNC_STAGES  = 2;
  localparam int HP_ARM_CYCLES   = 16;
  localparam int HP_FILTER       = 2;
  localparam int HP_CNT_W        = 8;
  localparam int HP_FAULT_THRESH = 3;

  // Bits needed for a counter that must be able to hold the value 'limit'
  function automatic int hp_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/hp_sync.sv
// Generic N-stage synchronizer for a single asynchronous bit. The reset value
// is a parameter so a sensor alarm can be treated as asserted out of reset.
module hp_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;

  // Shift the raw input through the chain; bit 0 is the metastability catcher
  always_ff @(posedge clk) begin
    if (srst) begin
      stage_reg <= {STAGES{RST_VAL}};
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], d};
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/hp_alarm_ctrl.sv
// Alarm qualification stage for the hogge glitch sensor: synchronizes the raw
// alarm, waits for the oscillator to settle, filters short spurs, counts
// qualified glitch events and raises a sticky fault at a threshold.
module hp_alarm_ctrl
  import hp_pkg::*;
#(
  parameter int SYNC_STAGES  = HP_SYNC_STAGES,
  parameter int ARM_CYCLES   = HP_ARM_CYCLES,
  parameter int FILTER       = HP_FILTER,
  parameter int CNT_W        = HP_CNT_W,
  parameter int FAULT_THRESH = HP_FAULT_THRESH
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             Alarm,
  input  logic             clear,
  output logic             armed,
  output logic             fault,
  output logic             event_pulse,
  output logic [CNT_W-1:0] event_count
);

  localparam int SW = hp_cnt_width(ARM_CYCLES);
  localparam int FW = hp_cnt_width(FILTER);

  localparam logic [SW-1:0]    STABLE_LAST = SW'(ARM_CYCLES - 1);
  localparam logic [FW-1:0]    RUN_LAST    = FW'(FILTER - 1);
  localparam logic [FW-1:0]    RUN_DONE    = FW'(FILTER);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH      = CNT_W'(FAULT_THRESH);

  logic a_s;

  hp_state_e        state_reg, state_next;
  logic [SW-1:0]    stable_cnt_reg, stable_cnt_next;
  logic [FW-1:0]    run_cnt_reg, run_cnt_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             pulse_reg, pulse_next;
  logic             armed_reg, armed_next;
  logic             fault_reg, fault_next;
  logic [CNT_W-1:0] count_inc;
  logic             fire;

  // Alarm is taken as asserted out of reset until the chain flushes
  hp_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_alarm_sync (
    .clk (CK),
    .srst(RST),
    .d   (Alarm),
    .q   (a_s)
  );

  // Saturating increment of the event counter
  assign count_inc = (count_reg == CNT_MAX) ? count_reg : count_reg + 1'b1;

  // State and counter registers; reset overrides every other input
  always_ff @(posedge CK) begin
    if (RST) begin
      state_reg      <= ARMING;
      stable_cnt_reg <= '0;
      run_cnt_reg    <= '0;
      count_reg      <= '0;
      pulse_reg      <= 1'b0;
      armed_reg      <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      stable_cnt_reg <= stable_cnt_next;
      run_cnt_reg    <= run_cnt_next;
      count_reg      <= count_next;
      pulse_reg      <= pulse_next;
      armed_reg      <= armed_next;
      fault_reg      <= fault_next;
    end
  end

  // Next-state logic: arming, run-length filtering, counting and clear
  always_comb begin
    state_next      = state_reg;
    stable_cnt_next = stable_cnt_reg;
    run_cnt_next    = run_cnt_reg;
    count_next      = count_reg;
    pulse_next      = 1'b0;
    fire            = 1'b0;

    unique case (state_reg)
      ARMING: begin
        // Wait for ARM_CYCLES consecutive quiet cycles; no event counting
        run_cnt_next = '0;
        if (a_s) begin
          stable_cnt_next = '0;
        end else if (stable_cnt_reg == STABLE_LAST) begin
          stable_cnt_next = '0;
          state_next      = MONITOR;
        end else begin
          stable_cnt_next = stable_cnt_reg + 1'b1;
        end
        if (clear) begin
          count_next = '0;
        end
      end

      MONITOR, FAULT: begin
        stable_cnt_next = '0;
        // Run-length filter: one event per continuous high run of FILTER+
        if (!a_s) begin
          run_cnt_next = '0;
        end else if (run_cnt_reg == RUN_LAST) begin
          fire         = 1'b1;
          run_cnt_next = RUN_DONE;
        end else if (run_cnt_reg != RUN_DONE) begin
          run_cnt_next = run_cnt_reg + 1'b1;
        end

        // Events keep counting in FAULT so the history stays visible
        if (fire) begin
          pulse_next = 1'b1;
          count_next = count_inc;
          if ((state_reg == MONITOR) && (count_inc >= THRESH)) begin
            state_next = FAULT;
          end
        end

        // Clear beats a simultaneous event; only FAULT is left on clear
        if (clear) begin
          pulse_next   = 1'b0;
          count_next   = '0;
          run_cnt_next = '0;
          if (state_reg == FAULT) begin
            state_next      = ARMING;
            stable_cnt_next = '0;
          end else begin
            state_next = state_reg;
          end
        end
      end

      default: begin
        state_next      = ARMING;
        stable_cnt_next = '0;
        run_cnt_next    = '0;
        count_next      = '0;
      end
    endcase

    armed_next = (state_next == MONITOR);
    fault_next = (state_next == FAULT);
  end

  assign armed       = armed_reg;
  assign fault       = fault_reg;
  assign event_pulse = pulse_reg;
  assign event_count = count_reg;

endmodule

// File: tb/tb_hp_alarm_ctrl.sv
// Self-checking bench for hp_alarm_ctrl. Each table row holds the inputs for
// a phase of N clock edges plus the outputs expected at its end and the
// pulse/armed/fault activity expected within it. A second instance with a
// 2-bit counter sees the same stimulus to check counter saturation.
module tb_hp_alarm_ctrl;

  typedef struct {
    logic rst;
    logic alarm;
    logic clr;
    int   n;
    logic armed;
    logic fault;
    int   count;
    int   pulses;
    int   first_pulse;
    int   armed_cyc;
    int   fault_cyc;
  } vec_t;

  localparam int NV = 31;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       Alarm = 1'b0;
  logic       clear = 1'b0;
  logic       armed, fault, event_pulse;
  logic [7:0] event_count;
  logic       armed2, fault2, pulse2;
  logic [1:0] count2;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[NV];
  vec_t exp_q[$];

  hp_alarm_ctrl dut (
    .CK         (CK),
    .RST        (RST),
    .Alarm      (Alarm),
    .clear      (clear),
    .armed      (armed),
    .fault      (fault),
    .event_pulse(event_pulse),
    .event_count(event_count)
  );

  hp_alarm_ctrl #(.CNT_W(2), .FAULT_THRESH(3)) dut2 (
    .CK         (CK),
    .RST        (RST),
    .Alarm      (Alarm),
    .clear      (clear),
    .armed      (armed2),
    .fault      (fault2),
    .event_pulse(pulse2),
    .event_count(count2)
  );

  always #5 CK = ~CK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic rst, input logic alarm, input logic clr, input int n,
                              input logic a, input logic f, input int c, input int p,
                              input int fp, input int ac, input int fc);
    vec_t v;
    v.rst = rst; v.alarm = alarm; v.clr = clr; v.n = n;
    v.armed = a; v.fault = f; v.count = c; v.pulses = p;
    v.first_pulse = fp; v.armed_cyc = ac; v.fault_cyc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  initial begin
    vec_t v;
    vec_t e;
    int   pulses, pulses2, fp, acyc, fcyc, edges;
    bit   seen;

    //            rst  alm  clr   n  armed flt cnt pls 1st acyc fcyc
    vecs[0]  = mk(1'b1, 1'b0, 1'b0,  3, 1'b0, 1'b0, 0, 0, 0,  0, 0); // reset
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 30, 1'b0, 1'b0, 0, 0, 0,  0, 0); // start-up alarm
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 20, 1'b1, 1'b0, 0, 0, 0,  3, 0); // arms at edge 18
    vecs[3]  = mk(1'b0, 1'b1, 1'b0,  1, 1'b1, 1'b0, 0, 0, 0,  1, 0); // 1-cycle spur
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0, 0, 0, 0, 10, 0);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0,  2, 1'b1, 1'b0, 0, 0, 0,  2, 0); // 2-cycle high
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0, 1, 1, 2, 10, 0); // 4 edges after rise
    vecs[7]  = mk(1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b0, 0, 0, 0,  1, 0); // clear in MONITOR
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 50, 1'b1, 1'b0, 1, 1, 4, 50, 0); // long run
    vecs[9]  = mk(1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b0, 1, 0, 0,  3, 0);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b0, 2, 1, 4, 10, 0); // second run
    vecs[11] = mk(1'b0, 1'b0, 1'b0,  5, 1'b1, 1'b0, 2, 0, 0,  5, 0);
    vecs[12] = mk(1'b0, 1'b1, 1'b0,  6, 1'b0, 1'b1, 3, 1, 4,  3, 3); // third -> FAULT
    vecs[13] = mk(1'b0, 1'b0, 1'b0,  5, 1'b0, 1'b1, 3, 0, 0,  0, 5);
    vecs[14] = mk(1'b0, 1'b1, 1'b0,  6, 1'b0, 1'b1, 4, 1, 4,  0, 6); // counted in FAULT
    vecs[15] = mk(1'b0, 1'b0, 1'b0,  5, 1'b0, 1'b1, 4, 0, 0,  0, 5);
    vecs[16] = mk(1'b0, 1'b1, 1'b0,  6, 1'b0, 1'b1, 5, 1, 4,  0, 6); // fifth event
    vecs[17] = mk(1'b0, 1'b0, 1'b0,  5, 1'b0, 1'b1, 5, 0, 0,  0, 5);
    vecs[18] = mk(1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b0, 0, 0, 0,  0, 0); // clear FAULT
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 20, 1'b1, 1'b0, 0, 0, 0,  5, 0); // re-arm at 16
    vecs[20] = mk(1'b0, 1'b1, 1'b0,  6, 1'b1, 1'b0, 1, 1, 4,  6, 0);
    vecs[21] = mk(1'b0, 1'b0, 1'b0,  5, 1'b1, 1'b0, 1, 0, 0,  5, 0);
    vecs[22] = mk(1'b0, 1'b1, 1'b0,  6, 1'b1, 1'b0, 2, 1, 4,  6, 0);
    vecs[23] = mk(1'b0, 1'b0, 1'b0,  5, 1'b1, 1'b0, 2, 0, 0,  5, 0);
    vecs[24] = mk(1'b0, 1'b1, 1'b0,  3, 1'b1, 1'b0, 2, 0, 0,  3, 0); // one short of event
    vecs[25] = mk(1'b0, 1'b1, 1'b1,  1, 1'b1, 1'b0, 0, 0, 0,  1, 0); // clear vs event
    vecs[26] = mk(1'b0, 1'b1, 1'b0,  4, 1'b1, 1'b0, 1, 1, 2,  4, 0); // run restarts
    vecs[27] = mk(1'b0, 1'b0, 1'b0,  5, 1'b1, 1'b0, 1, 0, 0,  5, 0);
    vecs[28] = mk(1'b0, 1'b1, 1'b0,  3, 1'b1, 1'b0, 1, 0, 0,  3, 0);
    vecs[29] = mk(1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b0, 0, 0, 0,  0, 0); // reset mid-run
    vecs[30] = mk(1'b0, 1'b0, 1'b0, 20, 1'b1, 1'b0, 0, 0, 0,  3, 0); // start-up timing

    for (int i = 0; i < NV; i++) begin
      // Drive a phase and queue what it should produce
      v     = vecs[i];
      RST   = v.rst;
      Alarm = v.alarm;
      clear = v.clr;
      exp_q.push_back(v);

      pulses = 0; pulses2 = 0; fp = 0; acyc = 0; fcyc = 0;
      for (int k = 1; k <= v.n; k++) begin
        tick();
        if (event_pulse === 1'b1) begin
          pulses++;
          if (fp == 0) fp = k;
        end
        if (pulse2 === 1'b1) pulses2++;
        if (armed === 1'b1) acyc++;
        if (fault === 1'b1) fcyc++;
      end

      // Compare what the DUTs produced against the queued expectation
      e = exp_q.pop_front();
      $display("phase %0d: rst=%0b alarm=%0b clear=%0b x%0d -> armed=%0b fault=%0b count=%0d pulses=%0d count2=%0d",
               i, e.rst, e.alarm, e.clr, e.n, armed, fault, event_count, pulses, count2);
      chk($sformatf("p%0d armed", i), 32'(armed), 32'(e.armed));
      chk($sformatf("p%0d fault", i), 32'(fault), 32'(e.fault));
      chk($sformatf("p%0d event_count", i), 32'(event_count), 32'(e.count));
      chk($sformatf("p%0d pulses", i), 32'(pulses), 32'(e.pulses));
      chk($sformatf("p%0d first_pulse_edge", i), 32'(fp), 32'(e.first_pulse));
      chk($sformatf("p%0d armed_cycles", i), 32'(acyc), 32'(e.armed_cyc));
      chk($sformatf("p%0d fault_cycles", i), 32'(fcyc), 32'(e.fault_cyc));
      chk($sformatf("p%0d sat_count", i), 32'(count2), 32'((e.count > 3) ? 3 : e.count));
      chk($sformatf("p%0d sat_fault", i), 32'(fault2), 32'(e.fault));
      chk($sformatf("p%0d sat_armed", i), 32'(armed2), 32'(e.armed));
      chk($sformatf("p%0d sat_pulses", i), 32'(pulses2), 32'(e.pulses));
    end

    // Hand sequence: bounded wait for the event pulse after a fresh rise
    Alarm = 1'b1;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 20) begin
      tick();
      edges++;
      if (event_pulse === 1'b1) seen = 1'b1;
    end
    $display("latency: pulse seen=%0b after %0d edges, count=%0d", seen, edges, event_count);
    chk("latency_pulse_seen", 32'(seen), 32'(1));
    chk("latency_edges", 32'(edges), 32'(4));
    chk("latency_count", 32'(event_count), 32'(1));
    tick();
    chk("pulse_one_cycle", 32'(event_pulse), 32'(0));

    Alarm = 1'b0;
    for (int k = 0; k < 5; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
